// File: rtl/execute_pkg.sv
// Shared encodings for the LEGv8 execute stage: op classes, ALU functions,
// multiply modes and the multi-cycle sequencer states.
// Imported by execute_multicycle and seq_muldiv_core.
package execute_pkg;

   // Operation class selected by decode. 2'b11 is unused and executes as ALU.
   typedef enum logic [1:0] {
      OPC_ALU = 2'b00,
      OPC_MUL = 2'b01,
      OPC_DIV = 2'b10
   } op_class_e;

   // Single-cycle ALU functions. Encodings with bit 3 set produce 0.
   typedef enum logic [3:0] {
      ALU_AND    = 4'b0000,
      ALU_ORR    = 4'b0001,
      ALU_ADD    = 4'b0010,
      ALU_EOR    = 4'b0011,
      ALU_LSL    = 4'b0100,
      ALU_LSR    = 4'b0101,
      ALU_SUB    = 4'b0110,
      ALU_PASS_B = 4'b0111
   } alu_op_e;

   // Multiply result selection. 2'b11 behaves as MM_MUL.
   localparam logic [1:0] MM_MUL   = 2'b00;
   localparam logic [1:0] MM_SMULH = 2'b01;
   localparam logic [1:0] MM_UMULH = 2'b10;

   // Sequencer states shared by the multiplier and divider.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ITER = 2'b01,
      ST_FIX  = 2'b10
   } state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Purpose: radix-2 shift-add multiplier / restoring divider sharing one datapath.
// Latency: WIDTH step cycles after start, then fix_result is valid in the FIX cycle.
// Backpressure: none here; the parent sequencer decides when to start and step.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   start               load operands (magnitudes) and reset the counter
//   is_div, mult_mode,  operation selection sampled at start
//   div_signed
//   operand_a/b         raw operands sampled at start
//   step                perform one iteration this cycle
//   skip                combinational: divide by zero, iteration can be skipped
//   done                counter has reached its last iteration
//   fix_result          sign-corrected, half-selected result (valid in FIX)
module seq_muldiv_core
   import execute_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic [1:0]       mult_mode,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             step,
   output logic             skip,
   output logic             done,
   output logic [WIDTH-1:0] fix_result
);

   localparam int CNT_W = $clog2(WIDTH);

   // Start-time operand conditioning
   logic             sign_use;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             hi_sel;

   // Datapath state: acc holds product high half / remainder,
   // mq holds multiplier then product low half / dividend then quotient.
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mq_q;
   logic [WIDTH-1:0] bm_q;
   logic [CNT_W-1:0] cnt_q;
   logic             div_q;
   logic             neg_q;
   logic             hi_q;
   logic             zero_q;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;

   // MUL and UMULH work on raw bit patterns; only SMULH and SDIV use magnitudes.
   assign sign_use = is_div ? div_signed : (mult_mode == MM_SMULH);
   assign a_neg    = sign_use & operand_a[WIDTH-1];
   assign b_neg    = sign_use & operand_b[WIDTH-1];
   // Magnitude of MIN is MIN itself as an unsigned value, which is exactly
   // what makes SDIV MIN/-1 wrap back to MIN.
   assign a_mag    = a_neg ? (~operand_a + WIDTH'(1)) : operand_a;
   assign b_mag    = b_neg ? (~operand_b + WIDTH'(1)) : operand_b;
   assign hi_sel   = (mult_mode == MM_SMULH) || (mult_mode == MM_UMULH);
   assign skip     = is_div && (operand_b == '0);

   // One multiply step: conditionally add multiplicand, shift {acc,mq} right.
   assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, bm_q} : '0);
   // One divide step: shift next dividend bit into the remainder, trial subtract.
   assign div_shift = {acc_q, mq_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, bm_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q  <= '0;
         mq_q   <= '0;
         bm_q   <= '0;
         cnt_q  <= '0;
         div_q  <= 1'b0;
         neg_q  <= 1'b0;
         hi_q   <= 1'b0;
         zero_q <= 1'b0;
      end else if (start) begin
         acc_q  <= '0;
         mq_q   <= a_mag;
         bm_q   <= b_mag;
         cnt_q  <= CNT_W'(WIDTH - 1);
         div_q  <= is_div;
         neg_q  <= a_neg ^ b_neg;
         hi_q   <= !is_div && hi_sel;
         zero_q <= skip;
      end else if (step) begin
         cnt_q <= cnt_q - CNT_W'(1);
         if (div_q) begin
            if (!div_diff[WIDTH]) begin
               acc_q <= div_diff[WIDTH-1:0];
               mq_q  <= {mq_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_q <= div_shift[WIDTH-1:0];
               mq_q  <= {mq_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_q <= mul_sum[WIDTH:1];
            mq_q  <= {mul_sum[0], mq_q[WIDTH-1:1]};
         end
      end
   end

   assign done = (cnt_q == '0);

   // Sign correction and half select, consumed by the parent in FIX.
   assign prod     = {acc_q, mq_q};
   assign prod_fix = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
   assign quot_fix = neg_q ? (~mq_q + WIDTH'(1)) : mq_q;

   always_comb begin
      fix_result = '0;
      if (div_q) begin
         fix_result = zero_q ? '0 : quot_fix;
      end else if (hi_q) begin
         fix_result = prod_fix[2*WIDTH-1:WIDTH];
      end else begin
         fix_result = prod_fix[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/execute_multicycle.sv
// Purpose: LEGv8 execute stage: 1-cycle ALU plus iterative MUL/SMULH/UMULH/SDIV/UDIV, NZCV register.
// Latency: ALU 1 cycle (back-to-back); mul/div WIDTH+2 cycles; divide by zero 2 cycles.
// Backpressure: in_ready low while a mul/div is in flight or flush is asserted; no output stall.
//
// Ports:
//   clk, reset, flush           clock, async active-high reset, synchronous abort
//   in_valid / in_ready         request handshake; all inputs captured on accept
//   op_class, alu_op,           operation selection (execute_pkg encodings)
//   mult_mode, div_signed
//   update_flags                write NZCV when this op completes
//   operand_a, operand_b        operands
//   result, out_valid           registered result with one-cycle valid pulse
//   busy                        multi-cycle op in progress
//   negative/zero/carry/overflow  NZCV register
module execute_multicycle
   import execute_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op_class,
   input  logic [3:0]       alu_op,
   input  logic [1:0]       mult_mode,
   input  logic             div_signed,
   input  logic             update_flags,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] result,
   output logic             out_valid,
   output logic             busy,
   output logic             negative,
   output logic             zero,
   output logic             carry,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t state_q;
   state_t state_d;

   logic accept;
   logic is_md;
   logic accept_alu;
   logic start_md;
   logic step;
   logic fix_fire;
   logic upd_q;

   logic             core_skip;
   logic             core_done;
   logic [WIDTH-1:0] core_result;

   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_sum;
   logic [CNT_W-1:0] shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;

   // ------------------------------------------------------------------
   // Handshake. Reset is folded in so nothing looks acceptable while the
   // unit is being held in reset.
   // ------------------------------------------------------------------
   assign in_ready   = (state_q == ST_IDLE) && !flush && !reset;
   assign accept     = in_valid && in_ready;
   assign is_md      = (op_class == OPC_MUL) || (op_class == OPC_DIV);
   assign accept_alu = accept && !is_md;
   assign start_md   = accept && is_md;
   assign busy       = (state_q != ST_IDLE);

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      step     = 1'b0;
      fix_fire = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_md) begin
               // Divide by zero has nothing to iterate; go straight to FIX.
               state_d = core_skip ? ST_FIX : ST_ITER;
            end
         end
         ST_ITER: begin
            step = 1'b1;
            if (core_done) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            fix_fire = !flush;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (flush) begin
         state_d = ST_IDLE;
      end
   end

   seq_muldiv_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk        (clk),
      .reset      (reset),
      .start      (start_md),
      .is_div     (op_class == OPC_DIV),
      .mult_mode  (mult_mode),
      .div_signed (div_signed),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .step       (step),
      .skip       (core_skip),
      .done       (core_done),
      .fix_result (core_result)
   );

   // ------------------------------------------------------------------
   // Single-cycle ALU. SUB is a + ~b + 1 so its carry out is NOT borrow.
   // ------------------------------------------------------------------
   assign add_sum = {1'b0, operand_a} + {1'b0, operand_b};
   assign sub_sum = {1'b0, operand_a} + {1'b0, ~operand_b} + (WIDTH+1)'(1);
   assign shamt   = operand_b[CNT_W-1:0];

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (alu_op_e'(alu_op))
         ALU_AND:    alu_res = operand_a & operand_b;
         ALU_ORR:    alu_res = operand_a | operand_b;
         ALU_EOR:    alu_res = operand_a ^ operand_b;
         ALU_PASS_B: alu_res = operand_b;
         ALU_LSL:    alu_res = operand_a << shamt;
         ALU_LSR:    alu_res = operand_a >> shamt;
         ALU_ADD: begin
            alu_res = add_sum[WIDTH-1:0];
            alu_c   = add_sum[WIDTH];
            alu_v   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                      (add_sum[WIDTH-1] != operand_a[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_res = sub_sum[WIDTH-1:0];
            alu_c   = sub_sum[WIDTH];
            alu_v   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                      (sub_sum[WIDTH-1] != operand_a[WIDTH-1]);
         end
         default:    alu_res = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Result, valid pulse and NZCV. A flush during FIX suppresses the
   // write, so an aborted op never touches result or flags.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result    <= '0;
         out_valid <= 1'b0;
         upd_q     <= 1'b0;
         negative  <= 1'b0;
         zero      <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         out_valid <= accept_alu || fix_fire;
         if (start_md) begin
            upd_q <= update_flags;
         end
         if (accept_alu) begin
            result <= alu_res;
            if (update_flags) begin
               negative <= alu_res[WIDTH-1];
               zero     <= (alu_res == '0);
               carry    <= alu_c;
               overflow <= alu_v;
            end
         end else if (fix_fire) begin
            result <= core_result;
            if (upd_q) begin
               negative <= core_result[WIDTH-1];
               zero     <= (core_result == '0);
               carry    <= 1'b0;
               overflow <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/execute_multicycle.md
Name: execute_multicycle

Overview:
- Parametrised execute stage for the LEGv8 core.
- Contains three functions:
  - single-cycle ALU
  - iterative multiplier: MUL, SMULH, UMULH
  - iterative divider: SDIV, UDIV
- One shared sequencer with a valid/ready handshake and a registered NZCV status register.
- Sits between decode/register-read and memory/writeback. Replaces the fixed-width ALU/mult/div arrangement with a single generic-width unit that supports flush.

Parameters:
- WIDTH, 64, operand/result width in bits; must be ≥4.
- CNT_W, $clog2(WIDTH), iteration counter width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous abort of any in-flight operation
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request this cycle
- op_class  input  2  ALU / MUL / DIV (package encodings)
- alu_op  input  4  ALU function (package encodings)
- mult_mode  input  2  00 MUL low half, 01 SMULH, 10 UMULH
- div_signed  input  1  1 = SDIV, 0 = UDIV
- update_flags  input  1  write NZCV on completion
- operand_a  input  WIDTH  first operand
- operand_b  input  WIDTH  second operand (immediate already muxed upstream)
- result  output  WIDTH  registered result
- out_valid  output  1  one-cycle pulse; result valid
- busy  output  1  multi-cycle op in progress (stall to hazard unit)
- negative, zero, carry, overflow  output  1 each  NZCV register

Behaviour:
- Reset (async): state IDLE; result, out_valid, busy and NZCV all 0. in_ready = 1 once reset deasserts.
- Handshake:
  - in_ready = (state == IDLE) && !flush.
  - Accept when in_valid && in_ready. All inputs are captured at accept; inputs are don't-care afterwards.
- ALU ops:
  - Accept in cycle 0; result and out_valid in cycle 1.
  - State stays IDLE, so back-to-back ALU ops issue every cycle.
  - Functions: AND, ORR, EOR, ADD, SUB, PASS_B, LSL, LSR. Shift amount is operand_b[CNT_W-1:0].
  - Flags:
    - ADD/SUB: C = carry out (SUB carry = NOT borrow); V = signed overflow.
    - Logical/shift ops: C = V = 0.
    - N and Z always from the result.
- MUL/DIV ops:
  - Accept in cycle 0 → state ITER; busy = 1 from cycle 1.
  - ITER runs cycles 1..WIDTH; counter starts at WIDTH-1 and ends at 0.
  - FIX in cycle WIDTH+1: sign correction and half select.
  - Result and out_valid in cycle WIDTH+2. That same cycle: state IDLE, busy = 0, in_ready = 1.
- Multiply:
  - Radix-2 shift-add on operand magnitudes into a 2*WIDTH product; negate in FIX if the signs differ (SMULH only).
  - MUL returns the low WIDTH bits (sign-agnostic). SMULH/UMULH return the high WIDTH bits.
  - mult_mode 11 behaves as MUL.
- Divide:
  - Restoring division on magnitudes; quotient negated in FIX when SDIV and the signs differ.
  - Truncation is toward zero.
  - Divisor 0: result = 0, no iteration. Skips ITER; FIX in cycle 1, out_valid in cycle 2.
  - SDIV of MIN by -1: result = MIN (wraps).
- MUL/DIV flags when update_flags: N = result[WIDTH-1], Z = (result == 0), C = V = 0.
- NZCV:
  - Written only in the cycle out_valid rises, and only if the captured update_flags = 1.
  - Otherwise held.
- Flush:
  - Any state → IDLE next cycle. busy = 0; no out_valid for the aborted op; NZCV unchanged; result holds its previous value.
  - flush and in_valid together: not accepted.
  - flush in the out_valid cycle: that pulse still occurs, since it was already registered.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.

Decomposition:
- Package execute_pkg:
  - op_class encodings: ALU 00, MUL 01, DIV 10.
  - alu_op encodings: AND 0000, ORR 0001, ADD 0010, EOR 0011, LSL 0100, LSR 0101, SUB 0110, PASS_B 0111.
  - mult_mode encodings.
  - FSM state encodings: IDLE, ITER, FIX.
- Sub-module seq_muldiv_core:
  - Contains the shared WIDTH-bit accumulator/remainder datapath, the iteration counter, magnitude conversion and sign fix.
  - Controlled by start/mode; reports done.
- Top level holds the ALU, NZCV register, handshake and flush.

Test Plan:
- WIDTH=64, ADD 0x7FFF_FFFF_FFFF_FFFF + 1 with update_flags=1 → result 0x8000_0000_0000_0000 in cycle 1; N=1, Z=0, C=0, V=1.
- Back-to-back ALU: SUB 5−5 then ORR 0xF0|0x0F on consecutive cycles → out_valid two consecutive cycles, results 0 (Z=1, C=1) then 0xFF; in_ready stays 1.
- SMULH -2 × 3 (WIDTH=64) → out_valid exactly at cycle 66, result 0xFFFF_FFFF_FFFF_FFFF; busy high cycles 1..65; in_ready low for the same window.
- WIDTH=8: SDIV -7/2 → 0xFD (-3); UDIV 0xF9/2 → 0x7C; SDIV 0x80/0xFF → 0x80; UDIV 5/0 → 0 with out_valid at cycle 2.
- MUL accepted with update_flags=1, flush asserted at cycle 10 → no out_valid; NZCV unchanged; in_ready=1 at cycle 11; a new ALU op accepted at cycle 11 completes at cycle 12.
- Reset asserted asynchronously mid-DIV → all outputs 0 immediately; after release, a fresh UDIV 100/7 (WIDTH=64) returns 14.
